sram_100_qsys_slave_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing one Avalon-MM slave (SRAM controller / sysid-class control slave).

---
 rtl/sram_100_qsys_slave_arbiter_pkg.sv | 24 ++
 rtl/sram_100_qsys_slave_arbiter_rdlat_pipe.sv | 44 ++++
 rtl/sram_100_qsys_slave_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_100_qsys_slave_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_100_qsys_slave_arbiter_pkg.sv
// Shared definitions for the two-master SRAM slave arbiter: FSM states,
// master IDs and the round-robin pick used when both masters request together.
package sram_100_qsys_slave_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic MID_0 = 1'b0;
  localparam logic MID_1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

  // Only meaningful when at least one master is requesting.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) begin
      return ~last_grant;
    end
    return req0 ? MID_0 : MID_1;
  endfunction

endpackage

// File: rtl/sram_100_qsys_slave_arbiter_rdlat_pipe.sv
// Fixed-latency return tracker: remembers which master issued each accepted
// read so the slave's read data can be steered back DEPTH cycles later.
module sram_100_qsys_slave_arbiter_rdlat_pipe
  import sram_100_qsys_slave_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push_vld,
  input  logic push_id,
  output logic pop_vld,
  output logic pop_id
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] id_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // stage samples the previous stage's old value at the same clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_vld;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // NOTE: the ID bits carry no reset; they are only ever observed when the
  // matching valid bit is set, and that bit is cleared by reset.
  always_ff @(posedge clock) begin
    id_q[0] <= push_id;
    for (int i = 1; i < DEPTH; i++) begin
      id_q[i] <= id_q[i-1];
    end
  end

  assign pop_vld = vld_q[DEPTH-1];
  assign pop_id  = id_q[DEPTH-1];

endmodule

// File: rtl/sram_100_qsys_slave_arbiter.sv
// Two-master round-robin arbiter in front of one fixed-read-latency Avalon-MM
// slave: one command in flight on the slave port, reads routed back by issuer.
module sram_100_qsys_slave_arbiter
  import sram_100_qsys_slave_arbiter_pkg::*;
#(
  parameter  int ADDR_W = 20,
  parameter  int DATA_W = 32,
  parameter  int RD_LAT = 2,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic       req0, req1;
  logic       sel_read, sel_write;
  logic       accept;
  logic       pop_vld, pop_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Command path follows the registered grant, so it is stable across stalls.
  assign sel_read     = (grant_q == MID_1) ? m1_read       : m0_read;
  assign sel_write    = (grant_q == MID_1) ? m1_write      : m0_write;
  assign s_address    = (grant_q == MID_1) ? m1_address    : m0_address;
  assign s_writedata  = (grant_q == MID_1) ? m1_writedata  : m0_writedata;
  assign s_byteenable = (grant_q == MID_1) ? m1_byteenable : m0_byteenable;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    accept         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d = rr_pick(req0, req1, last_grant_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (grant_q == MID_1) begin
          m1_waitrequest = s_waitrequest;
        end else begin
          m0_waitrequest = s_waitrequest;
        end
        if (!(sel_read || sel_write)) begin
          // Granted master withdrew its request: drop the slot, keep RR order.
          state_d = ST_IDLE;
        end else begin
          s_write = sel_write;
          s_read  = sel_read & ~sel_write;
          if (!s_waitrequest) begin
            accept       = 1'b1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset is synchronous, so the registers may hold anything until the
    // first edge; keep the bus quiet for the whole reset window.
    if (reset) begin
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      accept         = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= MID_0;
      last_grant_q <= MID_1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  sram_100_qsys_slave_arbiter_rdlat_pipe #(
    .DEPTH (RD_LAT)
  ) u_rdlat_pipe (
    .clock    (clock),
    .reset    (reset),
    .push_vld (accept & s_read),
    .push_id  (grant_q),
    .pop_vld  (pop_vld),
    .pop_id   (pop_id)
  );

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop_vld & ~reset & (pop_id == MID_0);
  assign m1_readdatavalid = pop_vld & ~reset & (pop_id == MID_1);

endmodule

// File: tb/tb_sram_100_qsys_slave_arbiter.sv
// Scoreboard bench for the two-master SRAM arbiter: stimulus queues expected
// slave commands and read returns, a negedge monitor pops and compares them.
module tb_sram_100_qsys_slave_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef struct packed {
    logic              v0;
    logic              v1;
    logic [DATA_W-1:0] data;
  } rsp_t;

  typedef struct packed {
    int                due;
    logic [DATA_W-1:0] data;
  } slv_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest = 1'b0;
  logic [DATA_W-1:0] s_readdata = '0;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  int   acc_q[$];
  slv_t slv_q[$];

  sram_100_qsys_slave_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock            (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic m_idle(input int id);
    drive(id, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Holds the request until waitrequest drops; returns at the start of the next cycle.
  task automatic m_xfer(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    int   n;
    logic wreq;
    n = 0;
    drive(id, rd, wr, a, d, be);
    forever begin
      @(negedge clk);
      wreq = (id == 0) ? m0_waitrequest : m1_waitrequest;
      if (!wreq) break;
      n++;
      if (n >= 64) begin
        n_vec++;
        n_miss++;
        $display("FAIL m%0d_accept_timeout: still stalled after %0d cycles, addr %h", id, n, a);
        break;
      end
    end
    tick();
  endtask

  task automatic exp_rd(input logic [ADDR_W-1:0] a);
    exp_cmd_q.push_back('{wr: 1'b0, addr: a, wdata: '0, be: '0});
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    exp_cmd_q.push_back('{wr: 1'b1, addr: a, wdata: d, be: be});
  endtask

  task automatic exp_ret(input int id, input logic [DATA_W-1:0] d);
    exp_rsp_q.push_back('{v0: (id == 0), v1: (id == 1), data: d});
  endtask

  // Slave model: read data is 32'h5FAF_EBB8 ^ address, presented RD_LAT cycles after acceptance.
  always @(posedge clk) begin
    slv_t e;
    #1;
    while (slv_q.size() > 0 && slv_q[0].due < cyc) e = slv_q.pop_front();
    if (slv_q.size() > 0 && slv_q[0].due == cyc) begin
      e = slv_q.pop_front();
      s_readdata = e.data;
    end else begin
      s_readdata = '0;
    end
  end

  // Monitor: every slave acceptance and every readdatavalid pulse is matched against the queues.
  always @(negedge clk) begin
    cmd_t act_c, exp_c;
    rsp_t act_r, exp_r;
    int   acc;
    if (reset) begin
      acc_q.delete();
    end else begin
      if ((s_read || s_write) && !s_waitrequest) begin
        act_c = '{wr: s_write, addr: s_address,
                  wdata: s_write ? s_writedata : '0, be: s_write ? s_byteenable : '0};
        if (exp_cmd_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_slave_cmd: got %h with nothing expected (cycle %0d)", act_c, cyc);
        end else begin
          exp_c = exp_cmd_q.pop_front();
          check("slave_cmd", 64'(act_c), 64'(exp_c));
        end
        if (s_read) begin
          acc_q.push_back(cyc);
          slv_q.push_back('{due: cyc + RD_LAT, data: 32'h5FAF_EBB8 ^ 32'(s_address)});
        end
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        act_r = '{v0: m0_readdatavalid, v1: m1_readdatavalid,
                  data: m0_readdatavalid ? m0_readdata : m1_readdata};
        if (exp_rsp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_readdatavalid: got %h with nothing expected (cycle %0d)", act_r, cyc);
        end else begin
          exp_r = exp_rsp_q.pop_front();
          check("read_return", 64'(act_r), 64'(exp_r));
        end
        if (acc_q.size() > 0) begin
          acc = acc_q.pop_front();
          check("read_latency", 64'(cyc - acc), 64'(RD_LAT));
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 5000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2;

    // Reset with both masters requesting.
    drive(0, 1'b1, 1'b0, 20'h00000, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 20'h00200, '0, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("t1_in_reset", 64'({m0_waitrequest, m1_waitrequest, s_read, s_write,
                                m0_readdatavalid, m1_readdatavalid}), 64'(6'b110000));
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t1_first_cycle_after", 64'({m0_waitrequest, m1_waitrequest, s_read, s_write}), 64'(4'b1100));
    tick();

    // Both masters read continuously: grants alternate starting with m0.
    exp_rd(20'h00000); exp_ret(0, 32'h5FAF_EBB8);
    exp_rd(20'h00200); exp_ret(1, 32'h5FAF_E9B8);
    exp_rd(20'h00104); exp_ret(0, 32'h5FAF_EABC);
    exp_rd(20'h00204); exp_ret(1, 32'h5FAF_E9BC);
    exp_rd(20'h00108); exp_ret(0, 32'h5FAF_EAB0);
    exp_rd(20'h00208); exp_ret(1, 32'h5FAF_E9B0);
    fork
      begin
        m_xfer(0, 1'b1, 1'b0, 20'h00000, '0, 4'hF);
        m_xfer(0, 1'b1, 1'b0, 20'h00104, '0, 4'hF);
        m_xfer(0, 1'b1, 1'b0, 20'h00108, '0, 4'hF);
        m_idle(0);
      end
      begin
        m_xfer(1, 1'b1, 1'b0, 20'h00200, '0, 4'hF);
        m_xfer(1, 1'b1, 1'b0, 20'h00204, '0, 4'hF);
        m_xfer(1, 1'b1, 1'b0, 20'h00208, '0, 4'hF);
        m_idle(1);
      end
    join
    repeat (4) tick();

    // m1 write stalled by the slave for 3 cycles while m0 waits with a read.
    exp_wr(20'h00010, 32'hDEAD_BEEF, 4'hF);
    exp_rd(20'h00300); exp_ret(0, 32'h5FAF_E8B8);
    s_waitrequest = 1'b1;
    drive(1, 1'b0, 1'b1, 20'h00010, 32'hDEAD_BEEF, 4'hF);
    tick();
    drive(0, 1'b1, 1'b0, 20'h00300, '0, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_hold", 64'({s_write, s_read, m0_waitrequest, m1_waitrequest, s_address, s_writedata}),
            64'({1'b1, 1'b0, 1'b1, 1'b1, 20'h00010, 32'hDEAD_BEEF}));
      tick();
    end
    s_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_accept_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b10));
    tick();
    m_idle(1);
    m_xfer(0, 1'b1, 1'b0, 20'h00300, '0, 4'hF);
    m_idle(0);
    repeat (4) tick();

    // m0 alone: re-granted every transaction, one command per two cycles.
    exp_rd(20'h00400); exp_ret(0, 32'h5FAF_EFB8);
    exp_rd(20'h00404); exp_ret(0, 32'h5FAF_EFBC);
    exp_rd(20'h00408); exp_ret(0, 32'h5FAF_EFB0);
    m_xfer(0, 1'b1, 1'b0, 20'h00400, '0, 4'hF);
    t0 = cyc;
    m_xfer(0, 1'b1, 1'b0, 20'h00404, '0, 4'hF);
    t1 = cyc;
    m_xfer(0, 1'b1, 1'b0, 20'h00408, '0, 4'hF);
    t2 = cyc;
    m_idle(0);
    check("t4_rate_a", 64'(t1 - t0), 64'd2);
    check("t4_rate_b", 64'(t2 - t1), 64'd2);
    repeat (4) tick();

    // m1 read in flight while m0 writes: only m1 gets read data.
    exp_rd(20'h00500); exp_ret(1, 32'h5FAF_EEB8);
    exp_wr(20'h00504, 32'h1234_5678, 4'b0011);
    m_xfer(1, 1'b1, 1'b0, 20'h00500, '0, 4'hF);
    m_idle(1);
    m_xfer(0, 1'b0, 1'b1, 20'h00504, 32'h1234_5678, 4'b0011);
    m_idle(0);
    repeat (4) tick();

    // Reset one cycle after a read is accepted: the return is dropped.
    exp_rd(20'h00600);
    m_xfer(0, 1'b1, 1'b0, 20'h00600, '0, 4'hF);
    m_idle(0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("t6_after_reset", 64'({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest,
                                   s_read, s_write}), 64'(6'b001100));
      tick();
    end

    repeat (8) tick();
    check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
